conv_ctrl: RTL
==============

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter n, default 10, meaning activation map side length.
REQ-002 SHALL have parameter k, default 3, meaning kernel side length.
REQ-003 SHALL have parameter s, default 1, meaning stride.
REQ-004 SHALL have parameter N, default 16, meaning data width.
REQ-005 SHALL have parameter AW, default 16, meaning activation and output address width.
REQ-006 SHALL have port `clk`, input, 1 bit, the single clock.
REQ-007 SHALL have port `global_rst_n`, input, 1 bit, an asynchronous active-low reset.
REQ-008 SHALL have port `start`, input, 1 bit, a one-cycle request to begin a convolution pass.
REQ-009 SHALL have output ports `busy`, `done` and `err`, each 1 bit, carrying status.
REQ-010 SHALL have ports `act_rd_en` (output, 1 bit), `act_rd_addr` (output, AW bits) and `act_rd_data` (input, N bits) for a synchronous activation RAM with 1-cycle read latency.
REQ-011 SHALL have ports `conv_ce` (output, 1), `conv_rst` (output, 1, active-high) and `conv_act` (output, N) driving the convolver.
REQ-012 SHALL have ports `conv_op` (input, N), `conv_valid` (input, 1) and `conv_end` (input, 1) from the convolver.
REQ-013 SHALL have ports `out_wr_en` (output, 1), `out_wr_addr` (output, AW) and `out_wr_data` (output, N) to the output buffer.

Function
REQ-014 SHALL implement FSM states IDLE, CLEAR, STREAM, DRAIN and FIN.
REQ-015 IDLE -> CLEAR on `start`; `start` in any other state SHALL be ignored.
REQ-016 CLEAR SHALL last exactly 1 cycle with `conv_rst`=1, reset the read address and output count to 0, and clear `err`; it then goes to STREAM.
REQ-017 STREAM SHALL assert `act_rd_en` for exactly n*n consecutive cycles with `act_rd_addr` = 0..n*n-1, then go to DRAIN.
REQ-018 `conv_ce` SHALL be `act_rd_en` delayed one cycle, and `conv_act` SHALL equal `act_rd_data` combinationally.
REQ-019 DRAIN SHALL hold `conv_ce`=1 with `conv_act`=0 (once the last streamed word has been consumed) until the output count reaches M = ((n-k)/s+1)^2 (integer division) or `conv_end`=1.
REQ-020 DRAIN SHALL time out after n+k cycles; on timeout it SHALL set `err` and go to FIN.
REQ-021 On each `conv_valid`=1 while count<M, the block SHALL drive `out_wr_en`=1, `out_wr_addr`=count and `out_wr_data`=`conv_op` in the same cycle, then increment count.
REQ-022 `conv_valid` with count>=M SHALL NOT write and SHALL set `err`.
REQ-023 `conv_valid` in IDLE, CLEAR or FIN SHALL be ignored.
REQ-024 FIN SHALL drive `done`=1 for exactly 1 cycle with `conv_ce`=0, then go to IDLE.
REQ-025 `err` SHALL be sticky until the next CLEAR.
REQ-026 `busy` SHALL be 1 in every state except IDLE.
REQ-027 Counters SHALL be sized with $clog2(n*n+1) bits and SHALL NOT wrap within one pass.

Reset
REQ-028 Asserting `global_rst_n`=0 SHALL immediately force IDLE, all counters to 0, and `busy`, `done`, `err`, `act_rd_en`, `conv_ce`, `out_wr_en`, `act_rd_addr` and `out_wr_addr` to 0.
REQ-029 While `global_rst_n`=0, `conv_rst` SHALL be 1.
REQ-030 Reset mid-pass SHALL abort the pass with no further writes.
REQ-031 Deassertion SHALL be synchronised through a 2-flop synchroniser before it releases the FSM.

Configuration
REQ-032 With CONV_CTRL_RELU_EN defined, `out_wr_data` SHALL be 0 whenever `conv_op`[N-1]=1, and `conv_op` otherwise.
REQ-033 Without CONV_CTRL_RELU_EN, `out_wr_data` SHALL equal `conv_op` unmodified.

Structure
REQ-034 Package conv_pkg SHALL hold the FSM state enum, the OUT_DIM(n,k,s) constant function and the DRAIN_MAX constant.
REQ-035 The write-address counter and the M-limit/error logic SHALL be one sub-module, conv_out_addr_gen.

Verification
REQ-036 With n=10, k=3, s=1, one `start` and the convolver model SHALL give exactly 100 reads at addresses 0..99, 64 writes at addresses 0..63, one `done` pulse and `err`=0.
REQ-037 With n=10, k=3, s=2, the block SHALL produce 16 writes at addresses 0..15, then `done`.
REQ-038 `start` pulsed during STREAM SHALL leave the read sequence and write count unchanged.
REQ-039 A convolver model that withholds `conv_valid` after 60 outputs SHALL cause timeout after 13 DRAIN cycles, with `err`=1 and `done` pulsed.
REQ-040 `global_rst_n` low at read address 37 SHALL give all outputs 0 at once; a following `start` SHALL restart reads from address 0.
REQ-041 With CONV_CTRL_RELU_EN defined, `conv_op`=16'hF000 SHALL be written as 0 and 16'h0400 SHALL be written unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared state encoding and sizing helpers for the convolution pass controller.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StStream,
    StDrain,
    StFin
  } conv_state_e;

  // Output feature-map side length for an n x n map, k x k kernel and stride s.
  function automatic int unsigned OUT_DIM(input int unsigned n, input int unsigned k,
                                          input int unsigned s);
    return (n - k) / s + 1;
  endfunction

  // Cycles DRAIN may wait for the convolver pipeline to empty before giving up.
  function automatic int unsigned DRAIN_MAX(input int unsigned n, input int unsigned k);
    return n + k;
  endfunction

endpackage

// File: rtl/conv_out_addr_gen.sv
// Output-buffer write address counter with the M-limit check and sticky error flag.
// Define CONV_CTRL_RELU_EN to clamp negative convolver results to zero on write.
module conv_out_addr_gen #(
  parameter int unsigned N      = 16,
  parameter int unsigned AW     = 16,
  parameter int unsigned CW     = 7,
  parameter int unsigned MaxOut = 64
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          accept_i,
  input  logic          timeout_i,
  input  logic [N-1:0]  op_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic [N-1:0]  wr_data_o,
  output logic          full_o,
  output logic          err_o
);

  localparam logic [CW-1:0] MaxCnt = CW'(MaxOut);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  assign full_o    = (cnt_q >= MaxCnt);
  assign wr_en_o   = accept_i && !full_o;
  assign wr_addr_o = AW'(cnt_q);
  assign err_o     = err_q;

`ifdef CONV_CTRL_RELU_EN
  assign wr_data_o = op_i[N-1] ? '0 : op_i;
`else
  assign wr_data_o = op_i;
`endif

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (clear_i) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else begin
      if (wr_en_o) begin
        cnt_d = cnt_q + 1'b1;
      end
      // A result beyond the expected map size, or a stalled pipeline, poisons the pass.
      if ((accept_i && full_o) || timeout_i) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Convolution pass controller: streams an n x n activation map into the convolver and
// stores its results. Define CONV_CTRL_RELU_EN to zero negative results on write.
module conv_ctrl #(
  parameter int unsigned n  = 10,
  parameter int unsigned k  = 3,
  parameter int unsigned s  = 1,
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 16
) (
  input  logic          clk,
  input  logic          global_rst_n,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          act_rd_en,
  output logic [AW-1:0] act_rd_addr,
  input  logic [N-1:0]  act_rd_data,
  output logic          conv_ce,
  output logic          conv_rst,
  output logic [N-1:0]  conv_act,
  input  logic [N-1:0]  conv_op,
  input  logic          conv_valid,
  input  logic          conv_end,
  output logic          out_wr_en,
  output logic [AW-1:0] out_wr_addr,
  output logic [N-1:0]  out_wr_data
);
  import conv_pkg::*;

  localparam int unsigned NPix     = n * n;
  localparam int unsigned CW       = $clog2(n * n + 1);
  localparam int unsigned OutCount = OUT_DIM(n, k, s) * OUT_DIM(n, k, s);
  localparam int unsigned DrainMax = DRAIN_MAX(n, k);
  localparam int unsigned DW       = $clog2(DrainMax + 1);

  // Reset asserts asynchronously but releases the FSM two clocks after deassertion.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge global_rst_n) begin
    if (!global_rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  conv_state_e   state_q, state_d;
  logic [CW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          rd_en_q;
  logic          full, timeout, accept, clear;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    drain_d   = drain_q;
    timeout   = 1'b0;
    act_rd_en = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StClear;
      end
      StClear: begin
        rd_addr_d = '0;
        drain_d   = '0;
        state_d   = StStream;
      end
      StStream: begin
        act_rd_en = 1'b1;
        if (rd_addr_q == CW'(NPix - 1)) begin
          state_d = StDrain;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      StDrain: begin
        if (full || conv_end) begin
          state_d = StFin;
        end else if (drain_q == DW'(DrainMax - 1)) begin
          timeout = 1'b1;
          state_d = StFin;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      StFin: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      drain_q   <= '0;
      rd_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      drain_q   <= drain_d;
      rd_en_q   <= act_rd_en;
    end
  end

  assign busy        = (state_q != StIdle);
  assign conv_rst    = !rst_n || (state_q == StClear);
  assign act_rd_addr = AW'(rd_addr_q);
  assign conv_ce     = rd_en_q || (state_q == StDrain);
  // Once the final RAM word has been consumed, DRAIN feeds zeros to flush the pipeline.
  assign conv_act    = (state_q == StDrain && !rd_en_q) ? '0 : act_rd_data;
  assign accept      = conv_valid && (state_q == StStream || state_q == StDrain);
  assign clear       = (state_q == StClear);

  conv_out_addr_gen #(
    .N      (N),
    .AW     (AW),
    .CW     (CW),
    .MaxOut (OutCount)
  ) u_out_addr_gen (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .clear_i   (clear),
    .accept_i  (accept),
    .timeout_i (timeout),
    .op_i      (conv_op),
    .wr_en_o   (out_wr_en),
    .wr_addr_o (out_wr_addr),
    .wr_data_o (out_wr_data),
    .full_o    (full),
    .err_o     (err)
  );

endmodule
